// File: rtl/trunk_access_ctrl.sv
// Trunk column decoder access sequencer: round-robin arbitration between two
// requesters, then precharge / enable / capture / response timing for one access.
module trunk_access_ctrl #(
   parameter int unsigned PRE_CYC = 2,
   parameter int unsigned EN_CYC  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_write,
   input  logic       req0_col_mode,
   input  logic [4:0] req0_sel,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_write,
   input  logic       req1_col_mode,
   input  logic [4:0] req1_sel,
   output logic       precharge,
   output logic       trunk_enable,
   output logic       trunk_byte_mode,
   output logic [4:0] trunk_sel,
   output logic       wr_en,
   output logic       rd_capture,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic       rsp_err,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, PRE, EN, CAP, RSP} state_t;

   state_t     state, state_nx;
   logic [3:0] cnt;
   logic       last_grant;
   logic       grant_vld, grant_id;
   logic       g_write, g_mode, g_illegal;
   logic [4:0] g_sel;
   logic       write_q, mode_q, id_q, err_q;
   logic [4:0] sel_q;

   // Grant only while idle; on contention the requester not served last wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
         end else if (req0_valid) begin
            grant_vld = 1'b1;
         end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
      g_write   = grant_id ? req1_write    : req0_write;
      g_mode    = grant_id ? req1_col_mode : req0_col_mode;
      g_sel     = grant_id ? req1_sel      : req0_sel;
      g_illegal = ~g_mode && (g_sel[4:3] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         write_q    <= 1'b0;
         mode_q     <= 1'b0;
         id_q       <= 1'b0;
         err_q      <= 1'b0;
         sel_q      <= '0;
      end else begin
         state <= state_nx;
         if (state != PRE && state_nx == PRE)
            cnt <= 4'(PRE_CYC - 1);
         else if (state == PRE && state_nx == EN)
            cnt <= 4'(EN_CYC - 1);
         else if (cnt != '0)
            cnt <= cnt - 4'd1;
         if (grant_vld) begin
            write_q    <= g_write;
            mode_q     <= g_mode;
            sel_q      <= g_sel;
            id_q       <= grant_id;
            err_q      <= g_illegal;
            last_grant <= grant_id;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (grant_vld) state_nx = g_illegal ? RSP : PRE;
         PRE:  if (cnt == '0) state_nx = EN;
         EN:   if (cnt == '0) state_nx = CAP;
         CAP:  state_nx = RSP;
         RSP:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req0_ready      = grant_vld & ~grant_id;
      req1_ready      = grant_vld &  grant_id;
      precharge       = (state == PRE);
      trunk_enable    = (state == EN);
      wr_en           = (state == EN) & write_q;
      rd_capture      = (state == CAP) & ~write_q;
      rsp_valid       = (state == RSP);
      rsp_id          = (state == RSP) & id_q;
      rsp_err         = (state == RSP) & err_q;
      busy            = (state != IDLE);
      trunk_sel       = sel_q;
      trunk_byte_mode = mode_q;
   end

endmodule

// File: tb/tb_trunk_access_ctrl.sv
// Bench for trunk_access_ctrl: two instances (default and PRE=3/EN=2 timing)
// checked every cycle against a transaction-offset reference model.
module tb_trunk_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req0_write = 1'b0, req0_col_mode = 1'b0;
   logic       req1_valid = 1'b0, req1_write = 1'b0, req1_col_mode = 1'b0;
   logic [4:0] req0_sel = '0, req1_sel = '0;

   logic [1:0] req0_ready, req1_ready, precharge, trunk_enable, trunk_byte_mode;
   logic [1:0] wr_en, rd_capture, rsp_valid, rsp_id, rsp_err, busy;
   logic [4:0] trunk_sel [2];

   trunk_access_ctrl dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready[0]), .req0_write(req0_write),
      .req0_col_mode(req0_col_mode), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready[0]), .req1_write(req1_write),
      .req1_col_mode(req1_col_mode), .req1_sel(req1_sel),
      .precharge(precharge[0]), .trunk_enable(trunk_enable[0]),
      .trunk_byte_mode(trunk_byte_mode[0]), .trunk_sel(trunk_sel[0]),
      .wr_en(wr_en[0]), .rd_capture(rd_capture[0]), .rsp_valid(rsp_valid[0]),
      .rsp_id(rsp_id[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

   trunk_access_ctrl #(.PRE_CYC(3), .EN_CYC(2)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready[1]), .req0_write(req0_write),
      .req0_col_mode(req0_col_mode), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready[1]), .req1_write(req1_write),
      .req1_col_mode(req1_col_mode), .req1_sel(req1_sel),
      .precharge(precharge[1]), .trunk_enable(trunk_enable[1]),
      .trunk_byte_mode(trunk_byte_mode[1]), .trunk_sel(trunk_sel[1]),
      .wr_en(wr_en[1]), .rd_capture(rd_capture[1]), .rsp_valid(rsp_valid[1]),
      .rsp_id(rsp_id[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Reference model: an access is described only by its offset from the handshake.
   int         P [2] = '{2, 3};
   int         E [2] = '{1, 2};
   bit         m_busy [2] = '{0, 0};
   int         m_d    [2] = '{0, 0};
   bit         m_ill  [2] = '{0, 0};
   bit         m_wr   [2] = '{0, 0};
   bit         m_id   [2] = '{0, 0};
   bit         m_mode [2] = '{0, 0};
   bit         m_last [2] = '{1, 1};
   logic [4:0] m_sel  [2] = '{5'd0, 5'd0};

   function automatic bit [1:0] grant(input int i);
      bit gv, gid;
      gv  = !m_busy[i] && (req0_valid || req1_valid);
      gid = (req0_valid && req1_valid) ? !m_last[i] : req1_valid;
      return {gv, gid};
   endfunction

   function automatic int last_off(input int i);
      return m_ill[i] ? 1 : P[i] + E[i] + 2;
   endfunction

   always @(posedge clk) begin
      bit [1:0] g;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         g = grant(i);
         if (rst) begin
            m_busy[i] = 0; m_last[i] = 1; m_sel[i] = '0; m_mode[i] = 0;
         end else if (m_busy[i]) begin
            if (m_d[i] == last_off(i)) m_busy[i] = 0;
            else m_d[i]++;
         end else if (g[1]) begin
            m_wr[i]   = g[0] ? req1_write    : req0_write;
            m_mode[i] = g[0] ? req1_col_mode : req0_col_mode;
            m_sel[i]  = g[0] ? req1_sel      : req0_sel;
            m_ill[i]  = !m_mode[i] && (m_sel[i] > 5'd7);
            m_id[i]   = g[0];
            m_last[i] = g[0];
            m_busy[i] = 1;
            m_d[i]    = 1;
         end
      end
   end

   function automatic logic [15:0] expect_out(input int i);
      bit [1:0] g;
      bit r0, r1, pre, en, wr, cap, rsp, bsy;
      int d;
      g = grant(i);
      {r0, r1, pre, en, wr, cap, rsp, bsy} = '0;
      d = m_d[i];
      if (!m_busy[i]) begin
         r0 = g[1] && !g[0];
         r1 = g[1] && g[0];
      end else begin
         bsy = 1;
         if (m_ill[i]) rsp = (d == 1);
         else begin
            pre = (d <= P[i]);
            en  = (d > P[i]) && (d <= P[i] + E[i]);
            wr  = en && m_wr[i];
            cap = (d == P[i] + E[i] + 1) && !m_wr[i];
            rsp = (d == P[i] + E[i] + 2);
         end
      end
      return {r0, r1, pre, en, m_mode[i], m_sel[i], wr, cap, rsp,
              rsp & m_id[i], rsp & m_ill[i], bsy};
   endfunction

   int hs_cyc [2], rsp_cyc [2];
   bit rsp_err_seen [2];
   bit grants [$];

   always @(negedge clk) begin
      logic [15:0] act, exp_v;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            act = {req0_ready[i], req1_ready[i], precharge[i], trunk_enable[i],
                   trunk_byte_mode[i], trunk_sel[i], wr_en[i], rd_capture[i],
                   rsp_valid[i], rsp_id[i], rsp_err[i], busy[i]};
            exp_v = expect_out(i);
            n_vec++;
            if (act !== exp_v) begin
               n_err++;
               $display("FAIL cycle %0d dut%0d outputs: got %h expected %h", cyc, i, act, exp_v);
            end
            if ((req0_ready[i] && req0_valid) || (req1_ready[i] && req1_valid)) hs_cyc[i] = cyc;
            if (rsp_valid[i]) begin
               rsp_cyc[i] = cyc;
               rsp_err_seen[i] = rsp_err[i];
            end
         end
         if (req0_ready[0] && req0_valid) grants.push_back(1'b0);
         if (req1_ready[0] && req1_valid) grants.push_back(1'b1);
      end
   end

   task automatic check(input string name, input int got, input int exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40 && (busy != 2'b00); k++) tick();
      check("idle_wait", int'(busy), 0);
   endtask

   typedef struct {
      bit         id;
      bit         wr;
      bit         mode;
      logic [4:0] sel;
      int         lat_a;
      int         lat_b;
      bit         err;
   } vec_t;

   task automatic drive_req(input bit id, input bit wr, input bit mode, input logic [4:0] sel);
      req0_valid = !id; req0_write = wr; req0_col_mode = mode; req0_sel = sel;
      req1_valid = id;  req1_write = wr; req1_col_mode = mode; req1_sel = sel;
   endtask

   task automatic run_txn(input vec_t v);
      wait_idle();
      hs_cyc  = '{-100, -100};
      rsp_cyc = '{-1, -1};
      drive_req(v.id, v.wr, v.mode, v.sel);
      tick();
      req0_valid = 0; req1_valid = 0;
      for (int k = 0; k < 20 && (rsp_cyc[0] < 0 || rsp_cyc[1] < 0); k++) tick();
      check("latency_a", rsp_cyc[0] - hs_cyc[0], v.lat_a);
      check("latency_b", rsp_cyc[1] - hs_cyc[1], v.lat_b);
      check("rsp_err_a", int'(rsp_err_seen[0]), int'(v.err));
      tick();
      check("sel_hold", int'(trunk_sel[0]), int'(v.sel));
   endtask

   vec_t tbl [6];

   initial begin
      tbl[0] = '{0, 0, 1, 5'd19, 5, 7, 0};
      tbl[1] = '{1, 1, 0, 5'd5,  5, 7, 0};
      tbl[2] = '{0, 0, 0, 5'd12, 1, 1, 1};
      tbl[3] = '{1, 0, 0, 5'd7,  5, 7, 0};
      tbl[4] = '{0, 1, 0, 5'd8,  1, 1, 1};
      tbl[5] = '{1, 1, 1, 5'd31, 5, 7, 0};

      @(posedge clk); #1;
      chk_en = 1;
      tick();
      rst = 0;

      foreach (tbl[i]) run_txn(tbl[i]);

      // Reset while the enable pulse is active aborts the access silently.
      wait_idle();
      drive_req(0, 0, 1, 5'd3);
      tick();
      req0_valid = 0;
      for (int k = 0; k < 10 && !trunk_enable[0]; k++) tick();
      check("saw_enable", int'(trunk_enable[0]), 1);
      rst = 1;
      tick();
      rst = 0;
      check("rst_clear", int'({precharge[0], trunk_enable[0], wr_en[0], rd_capture[0],
                               rsp_valid[0], busy[0], trunk_sel[0]}), 0);
      rsp_cyc = '{-1, -1};
      repeat (8) tick();
      check("no_rsp_after_rst", rsp_cyc[0], -1);

      // Continuous contention alternates grants with one idle cycle between accesses.
      grants.delete();
      hs_cyc = '{-100, -100};
      req0_valid = 1; req0_write = 0; req0_col_mode = 1; req0_sel = 5'd9;
      req1_valid = 1; req1_write = 1; req1_col_mode = 0; req1_sel = 5'd2;
      begin
         int prev_hs, gap;
         prev_hs = -1;
         gap = 0;
         for (int k = 0; k < 60 && grants.size() < 4; k++) begin
            tick();
            if (hs_cyc[0] != prev_hs) begin
               if (prev_hs >= 0) gap = hs_cyc[0] - prev_hs;
               prev_hs = hs_cyc[0];
            end
         end
         check("contention_gap", gap, 6);
      end
      req0_valid = 0; req1_valid = 0;
      check("grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check($sformatf("grant_%0d", i), int'(grants[i]), i % 2);

      // Randomized traffic, including dropped requests and stray resets.
      for (int k = 0; k < 600; k++) begin
         req0_valid    = ($urandom_range(0, 3) != 0);
         req1_valid    = ($urandom_range(0, 3) != 0);
         req0_write    = 1'($urandom);
         req1_write    = 1'($urandom);
         req0_col_mode = 1'($urandom);
         req1_col_mode = 1'($urandom);
         req0_sel      = 5'($urandom);
         req1_sel      = 5'($urandom);
         rst           = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst = 0; req0_valid = 0; req1_valid = 0;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trunk_access_ctrl.md
Name: trunk_access_ctrl

Overview:
- Sequences accesses through the trunk column decoder: precharge, enable pulse, read capture, response.
- Arbitrates between two requesters (round-robin), one access in flight at a time.
- Latches each request's mode and select, drives the decoder inputs with the required timing, and flags illegal selects.
- Sits between requester logic (host port / compute sequencer) and the trunk decoder plus bitline periphery.

Parameters:
- PRE_CYC, 2, precharge duration in cycles (1..15).
- EN_CYC, 1, trunk enable pulse width in cycles (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an access pending.
- req0_ready  out  1  requester 0 accepted this cycle (handshake = valid & ready).
- req0_write  in  1  1 = write, 0 = read.
- req0_col_mode  in  1  1 = single-column mode (1-of-32), 0 = byte-lane mode (sel 0..7, replicated on 4 bytes).
- req0_sel  in  5  column or lane index.
- req1_valid, req1_ready, req1_write, req1_col_mode, req1_sel  same as requester 0.
- precharge  out  1  bitline precharge strobe.
- trunk_enable  out  1  decoder enable.
- trunk_byte_mode  out  1  decoder mode input; equals latched col_mode.
- trunk_sel  out  5  decoder select.
- wr_en  out  1  write driver enable.
- rd_capture  out  1  sense/capture strobe.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  requester index of the completed access.
- rsp_err  out  1  access rejected (illegal select).
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, PRE, EN, CAP, RSP. One cycle counter (4 bit) is shared by PRE and EN.
- Reset values (next edge with rst=1):
  - state=IDLE, counter=0, last_grant=1 (requester 0 wins first).
  - All outputs 0, including trunk_sel=0 and trunk_byte_mode=0.
- Arbitration and handshake:
  - Combinational grant in IDLE only.
  - If exactly one valid, grant it. If both valid, grant the one != last_grant.
  - reqN_ready = (state==IDLE) & grant==N. Ready is never high outside IDLE and never high for both requesters.
  - On handshake (cycle T): latch write, col_mode, sel and id; last_grant <= id.
  - A requester must hold valid and fields stable until ready. The controller takes no action on dropped requests.
- Illegal select: col_mode=0 with sel>7.
  - Accept normally, then IDLE->RSP directly. rsp_valid and rsp_err=1 at T+1.
  - precharge, trunk_enable, wr_en and rd_capture stay 0 throughout.
- Legal access timing:
  - PRE: cycles T+1 .. T+PRE_CYC. precharge=1.
  - EN: next EN_CYC cycles. trunk_enable=1; wr_en=1 if write.
  - CAP: 1 cycle. rd_capture=1 if read; trunk_enable=0.
  - RSP: 1 cycle. rsp_valid=1, rsp_err=0, rsp_id=latched id.
  - RSP -> IDLE. Total: rsp_valid at T+PRE_CYC+EN_CYC+2.
  - Next handshake can occur at earliest the cycle after RSP (back-to-back gap of 1 IDLE cycle).
- Output stability:
  - trunk_sel and trunk_byte_mode are registered: loaded at handshake, held through RSP, retained in IDLE (no glitch to 0).
  - precharge and trunk_enable are never high in the same cycle.
  - wr_en and rd_capture are never high in the same cycle.
- rsp_valid has no backpressure; responders must sample it in that cycle.
- Counter: loaded with PRE_CYC-1 on PRE entry and EN_CYC-1 on EN entry; the state advances when counter==0.
- Reset mid-operation: on any state, the next edge forces IDLE with all strobes and rsp_valid 0. No response is issued for the aborted access.
- rst has priority over a simultaneous handshake; the request is not accepted.

Test Plan:
- Single read, defaults: req0 valid, read, col_mode=1, sel=19 at T
  - -> req0_ready at T; precharge at T+1..T+2; trunk_enable at T+3; rd_capture at T+4.
  - -> rsp_valid, rsp_id=0, rsp_err=0 at T+5; trunk_sel=19 and trunk_byte_mode=1 held T+1..T+5.
- Byte-lane write: req1, col_mode=0, sel=5, write, PRE_CYC=3, EN_CYC=2
  - -> wr_en high exactly 2 cycles after 3 precharge cycles; rd_capture never high; rsp_valid at T+7, rsp_id=1.
- Illegal select: req0 col_mode=0, sel=12 -> rsp_valid and rsp_err=1 at T+1; no precharge, enable or wr_en pulses.
- Contention: both valid continuously for 4 accesses -> grants 0,1,0,1; ready never concurrent; IDLE gap of 1 cycle between accesses.
- Reset mid-EN: assert rst during trunk_enable -> next cycle all outputs 0, busy=0, no rsp_valid; a following req1+req0 contention grants req0 first.
- Post-RSP retention: after completion with sel=31 -> trunk_sel stays 31 in IDLE and trunk_enable stays 0 until the next access.
